// File: rtl/vec_divmod_unit_if.sv
// vec_divmod_unit_if: operand/result handshake bundle for vec_divmod_unit.
// The sgn field exists only when VDIVMOD_SIGNED_EN is defined.
interface vec_divmod_unit_if #(parameter int DATA_W = 64);
  logic in_valid, in_ready, op_mod, out_valid, out_ready;
  logic [1:0] ww;
  logic [0:DATA_W-1] op_a, op_b, result;
  logic [0:DATA_W/8-1] dz_flags;
`ifdef VDIVMOD_SIGNED_EN
  logic sgn;
  modport master (output in_valid, op_mod, ww, op_a, op_b, sgn, out_ready,
                  input in_ready, out_valid, result, dz_flags);
  modport slave (input in_valid, op_mod, ww, op_a, op_b, sgn, out_ready,
                 output in_ready, out_valid, result, dz_flags);
`else
  modport master (output in_valid, op_mod, ww, op_a, op_b, out_ready,
                  input in_ready, out_valid, result, dz_flags);
  modport slave (input in_valid, op_mod, ww, op_a, op_b, out_ready,
                 output in_ready, out_valid, result, dz_flags);
`endif
endinterface

// File: rtl/vec_divmod_unit.sv
// vec_divmod_unit: multi-cycle SIMD restoring divide/modulo, BPC quotient bits per clock.
// Define VDIVMOD_SIGNED_EN for two's-complement mode (sgn input, extra PREP cycle).
module vec_divmod_unit #(
  parameter int DATA_W = 64,
  parameter int BPC = 1
) (
  input logic clk,
  input logic reset,
  vec_divmod_unit_if.slave bus
);
  localparam int NF = DATA_W / 8;
  localparam int LB = $clog2(BPC);
`ifdef VDIVMOD_SIGNED_EN
  typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;
  logic sgn_r;
  logic [NF-1:0] qn_r, rn_r;
  logic [NF-1:0] qn_nx [4], rn_nx [4];
  logic [DATA_W-1:0] abs_a [4], abs_d [4];
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t state;
  logic [DATA_W-1:0] a_r, d_r, rem_r;
  logic [1:0] ww_r;
  logic mod_r;
  logic [6:0] cnt;
  logic [DATA_W-1:0] a_nx [4], rem_nx [4], res_nx [4];
  logic [NF-1:0] dz_nx [4];
  assign bus.in_ready = state == IDLE;
  // One datapath per element width; ww_r picks which one updates the state.
  for (genvar w = 0; w < 4; w++) begin : g_w
    localparam int EW = 8 << w;
    localparam int NE = DATA_W / EW;
    if (NE < NF) begin : g_z
      assign dz_nx[w][NF-NE-1:0] = '0;
`ifdef VDIVMOD_SIGNED_EN
      assign qn_nx[w][NF-1:NE] = '0;
      assign rn_nx[w][NF-1:NE] = '0;
`endif
    end
    for (genvar k = 0; k < NE; k++) begin : g_e
      logic [EW-1:0] q_o, r_o, rs;
      always_comb begin
        logic [EW-1:0] r, q, d;
        logic [EW:0] sh, t;
        r = rem_r[k*EW +: EW];
        q = a_r[k*EW +: EW];
        d = d_r[k*EW +: EW];
        for (int s = 0; s < BPC; s++) begin
          sh = {r, q[EW-1]};
          t = sh - {1'b0, d};
          q = {q[EW-2:0], sh >= {1'b0, d}};
          r = sh >= {1'b0, d} ? t[EW-1:0] : sh[EW-1:0];
        end
        q_o = q;
        r_o = r;
      end
      assign rs = mod_r ? r_o : q_o;
      assign a_nx[w][k*EW +: EW] = q_o;
      assign rem_nx[w][k*EW +: EW] = r_o;
      assign dz_nx[w][NF-NE+k] = d_r[k*EW +: EW] == '0;
`ifdef VDIVMOD_SIGNED_EN
      logic sa, sb;
      assign sa = sgn_r & a_r[k*EW+EW-1];
      assign sb = sgn_r & d_r[k*EW+EW-1];
      assign abs_a[w][k*EW +: EW] = sa ? -a_r[k*EW +: EW] : a_r[k*EW +: EW];
      assign abs_d[w][k*EW +: EW] = sb ? -d_r[k*EW +: EW] : d_r[k*EW +: EW];
      // A zero divisor keeps the all-ones quotient, i.e. -1.
      assign qn_nx[w][k] = (sa ^ sb) & (d_r[k*EW +: EW] != '0);
      assign rn_nx[w][k] = sa;
      assign res_nx[w][k*EW +: EW] = (mod_r ? rn_r[k] : qn_r[k]) ? -rs : rs;
`else
      assign res_nx[w][k*EW +: EW] = rs;
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      d_r <= '0;
      rem_r <= '0;
      ww_r <= '0;
      mod_r <= 1'b0;
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.result <= '0;
      bus.dz_flags <= '0;
`ifdef VDIVMOD_SIGNED_EN
      sgn_r <= 1'b0;
      qn_r <= '0;
      rn_r <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r <= bus.op_a;
          d_r <= bus.op_b;
          rem_r <= '0;
          ww_r <= bus.ww;
          mod_r <= bus.op_mod;
          cnt <= (7'd8 << bus.ww) >> LB;
`ifdef VDIVMOD_SIGNED_EN
          sgn_r <= bus.sgn;
          state <= PREP;
`else
          state <= RUN;
`endif
        end
`ifdef VDIVMOD_SIGNED_EN
        PREP: begin
          a_r <= abs_a[ww_r];
          d_r <= abs_d[ww_r];
          qn_r <= qn_nx[ww_r];
          rn_r <= rn_nx[ww_r];
          state <= RUN;
        end
`endif
        RUN: begin
          a_r <= a_nx[ww_r];
          rem_r <= rem_nx[ww_r];
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            bus.result <= res_nx[ww_r];
            bus.dz_flags <= dz_nx[ww_r];
          end
        end
        DONE: if (bus.out_ready) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_divmod_unit.sv
// tb_vec_divmod_unit: directed table vectors plus backpressure, reset and back-to-back sequences.
module tb_vec_divmod_unit;
  localparam int BPC = 1;
`ifdef VDIVMOD_SIGNED_EN
  localparam int LATX = 1;
`else
  localparam int LATX = 0;
`endif
  typedef struct {
    logic [1:0] w;
    logic m;
    logic [63:0] a, b, r;
    logic [7:0] dz;
  } vec_t;
  logic clk, reset;
  int n_tests = 0, n_fail = 0;
  vec_t tv [11];
  vec_divmod_unit_if #(.DATA_W(64)) bus();
  vec_divmod_unit #(.DATA_W(64), .BPC(BPC)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] mres(input logic [63:0] a, input logic [63:0] b, input logic [1:0] w, input logic m);
    logic [63:0] res = '0;
    int ew = 8 << w;
    logic [63:0] mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
    for (int e = 0; e < 64 / ew; e++) begin
      int sh = 64 - ew * (e + 1);
      logic [63:0] ea = (a >> sh) & mask;
      logic [63:0] eb = (b >> sh) & mask;
      logic [63:0] r = (eb == 0) ? (m ? ea : mask) : (m ? ea % eb : ea / eb);
      res |= r << sh;
    end
    return res;
  endfunction
  function automatic logic [7:0] mdz(input logic [63:0] b, input logic [1:0] w);
    logic [7:0] dz = '0;
    int ew = 8 << w;
    logic [63:0] mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
    for (int e = 0; e < 64 / ew; e++)
      if (((b >> (64 - ew * (e + 1))) & mask) == 0) dz |= 8'h80 >> e;
    return dz;
  endfunction
  task automatic issue(input logic [1:0] w, input logic m, input logic [63:0] a, input logic [63:0] b, output int lat);
    bus.ww = w;
    bus.op_mod = m;
    bus.op_a = a;
    bus.op_b = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a = ~a;
    bus.op_b = ~b;
    bus.ww = ~w;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  initial begin
    int lat, t, nres, g;
    logic acc;
    logic [63:0] ra [10], rb [10];
    logic [1:0] rw [10];
    logic rm [10];
    int ta [10];
    tv[0]  = '{2'd0, 1'b0, 64'hC8C8C8C8C8C8C8C8, 64'h0707070707070707, 64'h1C1C1C1C1C1C1C1C, 8'h00};
    tv[1]  = '{2'd3, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000010, 64'h000000000000000F, 8'h00};
    tv[2]  = '{2'd1, 1'b0, 64'h12340064FFFF0001, 64'h0000000A00000001, 64'hFFFF000AFFFF0001, 8'hA0};
    tv[3]  = '{2'd1, 1'b1, 64'h12340064FFFF0001, 64'h0000000A00000001, 64'h12340000FFFF0000, 8'hA0};
    tv[4]  = '{2'd2, 1'b0, 64'h00000064FFFFFFFF, 64'h0000000700010000, 64'h0000000E0000FFFF, 8'h00};
    tv[5]  = '{2'd2, 1'b1, 64'h00000064FFFFFFFF, 64'h0000000700010000, 64'h000000020000FFFF, 8'h00};
    tv[6]  = '{2'd0, 1'b1, 64'hFF100009807F01FE, 64'h1003050080FF0102, 64'h0F010009007F0000, 8'h10};
    tv[7]  = '{2'd0, 1'b0, 64'hFF100009807F01FE, 64'h1003050080FF0102, 64'h0F0500FF0100017F, 8'h10};
    tv[8]  = '{2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0000000000000001, 64'h0123456789ABCDEF, 8'h00};
    tv[9]  = '{2'd3, 1'b1, 64'hDEADBEEF00000000, 64'h0000000000000000, 64'hDEADBEEF00000000, 8'h80};
    tv[10] = '{2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFF000100028000, 64'h0001FFFF7FFF0001, 8'h00};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op_mod = 1'b0;
    bus.ww = 2'd0;
    bus.op_a = '0;
    bus.op_b = '0;
`ifdef VDIVMOD_SIGNED_EN
    bus.sgn = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 64'h0);
    chk("rst_dz", bus.dz_flags, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      issue(tv[i].w, tv[i].m, tv[i].a, tv[i].b, lat);
      chk($sformatf("vec%0d_result", i), bus.result, tv[i].r);
      chk($sformatf("vec%0d_dz", i), bus.dz_flags, tv[i].dz);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'((8 << tv[i].w) / BPC + LATX));
      chk($sformatf("vec%0d_busy", i), bus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
`ifdef VDIVMOD_SIGNED_EN
    bus.sgn = 1'b1;
    issue(2'd2, 1'b0, 64'hFFFFFFF980000000, 64'h00000002FFFFFFFF, lat);
    chk("sgn_quot", bus.result, 64'hFFFFFFFD80000000);
    chk("sgn_quot_latency", 64'(lat), 64'd33);
    @(posedge clk); #1;
    issue(2'd2, 1'b1, 64'hFFFFFFF980000000, 64'h00000002FFFFFFFF, lat);
    chk("sgn_rem", bus.result, 64'hFFFFFFFF00000000);
    chk("sgn_rem_dz", bus.dz_flags, 8'h00);
    @(posedge clk); #1;
    bus.sgn = 1'b0;
`endif
    bus.out_ready = 1'b0;
    issue(tv[2].w, tv[2].m, tv[2].a, tv[2].b, lat);
    chk("bp_first_valid", bus.out_valid, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_result_c%0d", c), bus.result, tv[2].r);
      chk($sformatf("bp_flags_c%0d", c), {bus.out_valid, bus.in_ready, bus.dz_flags}, {1'b1, 1'b0, tv[2].dz});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
    bus.ww = 2'd3;
    bus.op_mod = 1'b0;
    bus.op_a = 64'h123456789ABCDEF0;
    bus.op_b = 64'h3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_result", bus.result, 64'h0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_dz", bus.dz_flags, 8'h00);
    #3;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(tv[0].w, tv[0].m, tv[0].a, tv[0].b, lat);
    chk("post_rst_result", bus.result, tv[0].r);
    chk("post_rst_latency", 64'(lat), 64'((8 << tv[0].w) / BPC + LATX));
    @(posedge clk); #1;
    t = 0;
    nres = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom} >> $urandom_range(0, 60);
      if (i == 3) rb[i] = '0;
      rw[i] = 2'($urandom_range(0, 3));
      rm[i] = 1'($urandom_range(0, 1));
      bus.op_a = ra[i];
      bus.op_b = rb[i];
      bus.ww = rw[i];
      bus.op_mod = rm[i];
      bus.in_valid = 1'b1;
      g = 0;
      do begin
        acc = bus.in_ready;
        @(posedge clk); #1;
        t++;
        g++;
        if (bus.out_valid && nres < 10) begin
          chk($sformatf("b2b_res%0d", nres), bus.result, mres(ra[nres], rb[nres], rw[nres], rm[nres]));
          chk($sformatf("b2b_dz%0d", nres), bus.dz_flags, mdz(rb[nres], rw[nres]));
          nres++;
        end
      end while (!acc && g < 300);
      if (!acc) chk($sformatf("b2b_accept%0d", i), 1'b0, 1'b1);
      ta[i] = t;
      if (i > 0) chk($sformatf("b2b_spacing%0d", i), 64'(ta[i] - ta[i-1]), 64'((8 << rw[i-1]) / BPC + 2 + LATX));
    end
    bus.in_valid = 1'b0;
    g = 0;
    while (nres < 10 && g < 300) begin
      @(posedge clk); #1;
      g++;
      if (bus.out_valid) begin
        chk($sformatf("b2b_res%0d", nres), bus.result, mres(ra[nres], rb[nres], rw[nres], rm[nres]));
        chk($sformatf("b2b_dz%0d", nres), bus.dz_flags, mdz(rb[nres], rw[nres]));
        nres++;
      end
    end
    chk("b2b_count", 64'(nres), 64'd10);
    @(posedge clk); #1;
    chk("final_idle", {bus.in_ready, bus.out_valid}, 2'b10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_divmod_unit.md
# vec_divmod_unit

Multi-cycle SIMD integer divide/modulo unit for the vector execute stage, servicing VDIV and VMOD R-ALU instructions. It accepts two packed operand vectors and a WW element-width code, and runs an iterative restoring division in every lane in parallel. It returns either the quotient vector or the remainder vector through a valid/ready handshake, with defined divide-by-zero results and per-element flags. It sits beside the single-cycle ALU and stalls the pipeline through `in_ready`.

## Interface
- `DATA_W`, 64, vector width in bits; must be a multiple of 64.
- `BPC`, 1, quotient bits resolved per clock; legal values are 1, 2 and 4.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  unit can accept operands.
- `op_mod`  in  1  selects the result: 0 = quotient (VDIV), 1 = remainder (VMOD).
- `ww`  in  2  element width: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.
- `op_a`  in  [0:DATA_W-1]  dividend vector; bit 0 is the MSB, element 0 occupies the lowest indices.
- `op_b`  in  [0:DATA_W-1]  divisor vector, same packing as `op_a`.
- `sgn`  in  1  signed mode; present only when `VDIVMOD_SIGNED_EN` is defined.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  [0:DATA_W-1]  quotient or remainder vector.
- `dz_flags`  out  [0:DATA_W/8-1]  bit i is set when element i had a zero divisor; bits at or beyond the element count are 0.

## Operation
- The FSM has the states IDLE, PREP, RUN and DONE. PREP exists only in signed builds.
- `in_ready` = (state == IDLE).
- **Accept** (`in_valid && in_ready` at an edge):
  - latch `op_a`, `op_b`, `ww`, `op_mod` and `sgn`;
  - clear the partial remainders;
  - load the iteration counter with N = EW/BPC, where EW is the element width.
- **Next state after accept:** PREP in signed builds, RUN otherwise.
- **PREP:** replace each element with its absolute value and record the sign of the quotient and the remainder, then go to RUN.
- **RUN:** each edge performs BPC restoring steps per element.
  - Lane carries are cut at element boundaries.
  - The shifted-in dividend bits come from each element's own MSB first.
  - The counter decrements each edge; at counter == 1 the FSM goes to DONE.
- **DONE:**
  - `out_valid` = 1, and `result` and `dz_flags` are held stable.
  - On `out_valid && out_ready` the FSM returns to IDLE.
  - `in_valid` is ignored in DONE.
- **Arithmetic:** unsigned results satisfy q = floor(a/b) and r = a − q·b, each truncated to EW bits.
- **Divide by zero** (element divisor == 0):
  - q = all ones in EW bits;
  - r = dividend;
  - the element's `dz_flags` bit is set.
- Elements with a nonzero divisor are unaffected by a zero divisor in a neighbouring element.

## Timing
- **Reset values:**
  - state = IDLE, `in_ready` = 1;
  - `out_valid` = 0;
  - `result` = 0, `dz_flags` = 0.
- **Latency:** with acceptance at edge T0, `out_valid` rises after edge T0+N in unsigned builds and after edge T0+N+1 in signed builds.
- **N for BPC = 1:** 8, 16, 32 or 64 for WW = 00, 01, 10, 11.
- **Throughput:** there is no overlap between operations. `in_ready` rises the cycle after the output handshake, so the minimum issue interval is N+2 (unsigned build).
- **Backpressure:** while `out_ready` = 0 in DONE, the outputs hold indefinitely.
- **Input changes:** `op_a`, `op_b` and `ww` may change after acceptance without effect.
- **Reset mid-operation:** the operation is abandoned and all outputs return to their reset values on assertion. No partial result is ever presented.

## Configuration
- `VDIVMOD_SIGNED_EN` defined:
  - the `sgn` port and the PREP state exist;
  - `sgn` = 1 selects two's-complement division, with the quotient truncated toward zero and the remainder taking the sign of the dividend;
  - divide by zero gives q = −1 and r = dividend;
  - for most-negative ÷ −1, q = most-negative and r = 0, with no flag.
- `VDIVMOD_SIGNED_EN` undefined:
  - the unit is unsigned only, with no `sgn` port and no PREP state;
  - latency is N.

## Test plan
- **Unsigned 8-bit divide:** WW = 00, op_mod = 0, every byte of `op_a` = 0xC8 (200), every byte of `op_b` = 0x07.
  - Every result byte = 0x1C.
  - `out_valid` after 8 cycles with BPC = 1.
- **Unsigned 64-bit modulo:** WW = 11, op_mod = 1, a = 0xFFFF_FFFF_FFFF_FFFF, b = 0x10.
  - `result` = 0xF.
  - Latency 64 cycles with BPC = 1, 16 cycles with BPC = 4.
- **Mixed zero divisor:** WW = 01, a = {0x1234, 0x0064, 0xFFFF, 0x0001}, b = {0, 0x000A, 0, 0x0001}, op_mod = 0.
  - `result` = {0xFFFF, 0x000A, 0xFFFF, 0x0001}.
  - `dz_flags[0:3]` = 1010, remaining flag bits 0.
- **Backpressure and reset:** hold `out_ready` = 0 for 20 cycles in DONE.
  - `result` is stable and `in_ready` = 0 throughout.
  - Assert `reset` mid-RUN on the following operation: `out_valid` = 0, `result` = 0 and `in_ready` = 1 immediately.
- **Signed 32-bit (signed build):** sgn = 1, WW = 10, a = {−7, 0x8000_0000}, b = {2, −1}.
  - Quotient = {−3, 0x8000_0000}.
  - Remainder = {−1, 0}.
  - Latency N+1 = 33.
- **Back-to-back issue:** `in_valid` held high with `out_ready` = 1.
  - Accepts are spaced exactly N+2 cycles apart (unsigned build).
  - No operand is lost or duplicated over 10 consecutive random operations, checked against a reference model.
